// File: rtl/block_tiler.sv
// Raster-to-block tiler: buffers one BLK-row strip, then emits BLKxBLK windows left to right.
// Define BLOCK_TILER_FLIP_EN to pack each window rotated by 180 degrees.
module block_tiler #(
   parameter int unsigned N       = 16,
   parameter int unsigned IMG_W   = 128,
   parameter int unsigned BLK     = 8,
   localparam int unsigned NumBlk = IMG_W / BLK,
   localparam int unsigned BcW    = (NumBlk > 1) ? $clog2(NumBlk) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         pix_in,
   input  logic                 pix_valid,
   output logic                 pix_ready,
   output logic [N*BLK*BLK-1:0] win_out,
   output logic                 win_valid,
   input  logic                 win_ready,
   output logic [BcW-1:0]       blk_col
);

   localparam int unsigned RowW = $clog2(BLK);
   localparam int unsigned ColW = $clog2(IMG_W);
   localparam logic [RowW-1:0] RowLast = RowW'(BLK - 1);
   localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
   localparam logic [BcW-1:0]  BlkLast = BcW'(NumBlk - 1);

   if ((BLK < 2) || ((IMG_W % BLK) != 0)) begin : g_param_err
      $error("block_tiler: BLK must be >= 2 and IMG_W a multiple of BLK");
   end

   typedef enum logic [0:0] {StFill, StEmit} state_e;

   state_e                    state_q;
   logic [RowW-1:0]           row_q;
   logic [ColW-1:0]           col_q;
   logic [BcW-1:0]            blk_col_q;
   logic                      win_valid_q;
   logic                      pix_ready_q;
   logic [BLK*IMG_W*N-1:0]    strip_q;
   logic                      pix_acc;
   int unsigned               wr_base;

   assign pix_acc   = pix_valid && pix_ready_q;
   assign pix_ready = pix_ready_q;
   assign win_valid = win_valid_q;
   assign blk_col   = blk_col_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StFill;
         row_q       <= '0;
         col_q       <= '0;
         blk_col_q   <= '0;
         win_valid_q <= 1'b0;
         pix_ready_q <= 1'b1;
      end else begin
         unique case (state_q)
            StFill: begin
               if (pix_acc) begin
                  if (col_q == ColLast) begin
                     col_q <= '0;
                     if (row_q == RowLast) begin
                        row_q       <= '0;
                        state_q     <= StEmit;
                        win_valid_q <= 1'b1;
                        pix_ready_q <= 1'b0;
                     end else begin
                        row_q <= row_q + 1'b1;
                     end
                  end else begin
                     col_q <= col_q + 1'b1;
                  end
               end
            end
            StEmit: begin
               if (win_ready) begin
                  if (blk_col_q == BlkLast) begin
                     blk_col_q   <= '0;
                     state_q     <= StFill;
                     win_valid_q <= 1'b0;
                     pix_ready_q <= 1'b1;
                  end else begin
                     blk_col_q <= blk_col_q + 1'b1;
                  end
               end
            end
            default: state_q <= StFill;
         endcase
      end
   end

   always_comb begin
      wr_base = (32'(row_q) * IMG_W + 32'(col_q)) * N;
   end

   // Strip storage is never cleared; a reset simply restarts the write pointer.
   always_ff @(posedge clk) begin
      if (pix_acc) begin
         strip_q[wr_base +: N] <= pix_in;
      end
   end

   always_comb begin
      win_out = '0;
      if (win_valid_q) begin
         for (int r = 0; r < BLK; r++) begin
            for (int c = 0; c < BLK; c++) begin
`ifdef BLOCK_TILER_FLIP_EN
               win_out[((BLK-1-r)*BLK + (BLK-1-c))*N +: N] =
                  strip_q[(r*IMG_W + 32'(blk_col_q)*BLK + c)*N +: N];
`else
               win_out[(r*BLK + c)*N +: N] =
                  strip_q[(r*IMG_W + 32'(blk_col_q)*BLK + c)*N +: N];
`endif
            end
         end
      end
   end

endmodule

// File: doc/block_tiler.md
BLOCK_TILER -- requirements
Module: block_tiler

Interface
REQ-001 SHALL have parameter N, default 16, pixel width in bits (signed two's complement).
REQ-002 SHALL have parameter IMG_W, default 128, image width in pixels; must be a multiple of BLK.
REQ-003 SHALL have parameter BLK, default 8, window edge in pixels; BLK >= 2.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port pix_in, input, N bits: raster-order input pixel.
REQ-007 SHALL have port pix_valid, input, 1 bit: pix_in valid.
REQ-008 SHALL have port pix_ready, output, 1 bit: block accepts a pixel this cycle.
REQ-009 SHALL have port win_out, output, N*BLK*BLK bits: flat BLKxBLK window.
REQ-010 SHALL have port win_valid, output, 1 bit: win_out valid.
REQ-011 SHALL have port win_ready, input, 1 bit: downstream (dct2d) accepts window.
REQ-012 SHALL have port blk_col, output, clog2(IMG_W/BLK) bits (min 1): block-column index of current win_out.

Function
REQ-013 SHALL accept a pixel only on a cycle with pix_valid && pix_ready; input is row-major, IMG_W pixels per row, unbounded row count.
REQ-014 SHALL buffer one strip of BLK rows x IMG_W pixels (single strip buffer).
REQ-015 SHALL implement two states: FILL (pix_ready=1, win_valid=0) and EMIT (pix_ready=0, win_valid=1).
REQ-016 SHALL transition FILL->EMIT on the clock edge accepting the last pixel (row BLK-1, column IMG_W-1) of a strip; win_valid high the following cycle (latency 1 cycle).
REQ-017 SHALL in EMIT present windows for blk_col = 0,1,...,IMG_W/BLK-1 in order; advance on each cycle with win_valid && win_ready.
REQ-018 SHALL hold win_out and blk_col stable while win_valid && !win_ready.
REQ-019 SHALL transition EMIT->FILL on acceptance of window blk_col = IMG_W/BLK-1; pix_ready high the next cycle; row/column counters wrap to 0.
REQ-020 SHALL pack window element (r,c), r,c in 0..BLK-1, strip row r, image column blk_col*BLK+c, at win_out[(r*BLK+c)*N +: N] (default order).
REQ-021 SHALL ignore pix_valid during EMIT (no pixel loss: pix_ready=0 back-pressures source).
REQ-022 SHALL pass pixel values unmodified (no sign extension, rounding or saturation).
REQ-023 SHALL drive win_out to all zeros whenever win_valid=0.
REQ-024 SHALL reject illegal parameters (IMG_W % BLK != 0, BLK < 2) with an elaboration-time error.

Reset
REQ-025 SHALL on rst_n=0, asynchronously: state=FILL, row/column/block counters=0, win_valid=0, win_out=0, blk_col=0.
REQ-026 SHALL drive pix_ready=1 in the first cycle after rst_n deasserts.
REQ-027 SHALL on reset mid-FILL or mid-EMIT discard the partial strip; strip buffer contents need not be cleared.

Configuration
REQ-028 SHALL, with macro BLOCK_TILER_FLIP_EN defined, pack element (r,c) at win_out[((BLK-1-r)*BLK+(BLK-1-c))*N +: N] (180-degree window rotation, matching dct2d flipped-input convention).
REQ-029 SHALL, without BLOCK_TILER_FLIP_EN, use REQ-020 order; no other behaviour differs.

Verification
REQ-030 IMG_W=16, BLK=8, N=16, pixel(y,x)=y*16+x, win_ready=1 -> two windows, blk_col 0 then 1; window 1 element (0,0)=8, element (7,7)=127; win_valid 1 cycle after pixel 127 accepted.
REQ-031 Same stimulus, win_ready low 5 cycles on window 0 -> win_out/blk_col constant for 5 cycles; pix_ready=0 throughout EMIT; no pixel dropped.
REQ-032 Two consecutive strips (32 rows ... 16 rows), pix_valid toggling randomly -> second strip window 0 element (0,0)=128; pix_ready re-asserts one cycle after last window accepted.
REQ-033 rst_n pulsed low after 70 pixels of strip 0 -> win_valid=0 immediately; restarting strip yields window 0 element (0,0)=first post-reset pixel.
REQ-034 BLOCK_TILER_FLIP_EN defined, stimulus of REQ-030 -> window 0 win_out[0 +: 16]=119, win_out[63*16 +: 16]=0.
REQ-035 Negative pixels (-32768, -1) at element (3,4) -> win_out[(3*8+4)*16 +: 16] equals input bit-exact.
